// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared definitions for the FFT frame packer: error codes,
//                write-side state encoding, FIFO word layout helpers and the
//                frame-length legality check.
//  Revision    : 1.0  initial release
// ============================================================================
package fft_pkg;

  // Smallest frame length accepted unless the instance overrides it
  localparam int MIN_PTS_DEFAULT = 64;

  // Error field values carried with every beat
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DROP = 2'b01;

  // Write-side framing states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } wr_state_t;

  // FIFO word layout, LSB first: data | len | inverse | err[1:0] | eop | sop
  function automatic int ofs_data();
    return 0;
  endfunction

  function automatic int ofs_len(input int data_w);
    return data_w;
  endfunction

  function automatic int ofs_inv(input int data_w, input int pts_w);
    return data_w + pts_w;
  endfunction

  function automatic int ofs_err(input int data_w, input int pts_w);
    return data_w + pts_w + 1;
  endfunction

  function automatic int ofs_eop(input int data_w, input int pts_w);
    return data_w + pts_w + 3;
  endfunction

  function automatic int ofs_sop(input int data_w, input int pts_w);
    return data_w + pts_w + 4;
  endfunction

  function automatic int word_w(input int data_w, input int pts_w);
    return data_w + pts_w + 5;
  endfunction

  // A length is legal when it is a power of two within [min_pts, 2^(pts_w-1)]
  function automatic logic is_legal_len(input logic [31:0] len,
                                        input int unsigned min_pts,
                                        input int unsigned pts_w);
    logic pow2;
    pow2 = (len != 32'd0) && ((len & (len - 32'd1)) == 32'd0);
    return pow2 && (len >= min_pts) && (len <= (32'd1 << (pts_w - 1)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with a registered head word. The head and
//                its valid flag come straight from flops, so a word written
//                into an empty FIFO is visible one cycle later.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16   // power of two, at least 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_nxt;
  logic [AW:0]      rd_ptr_nxt;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Full is judged on the current occupancy, so a read in the same cycle
  // does not make room for the incoming word.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

  // Storage array write port
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointer update and head-word prefetch; a write landing on the new head
  // slot bypasses the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      rd_valid <= (wr_ptr_nxt != rd_ptr_nxt);
      if (push && (wr_ptr == rd_ptr_nxt)) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_ptr_nxt[AW-1:0]];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_packer
//  Description : Packs a free-running audio sample stream into Avalon-ST
//                frames for an FFT core. A frame starts on the first enabled
//                sample with a legal length and lasts exactly that many input
//                samples; samples meeting a full buffer are dropped, counted
//                and flagged on the remaining beats of the frame.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_frame_packer
  import fft_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int PTS_W      = 13,
  parameter int FIFO_DEPTH = 16,
  parameter int MIN_PTS    = MIN_PTS_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PTS_W-1:0]  fftpts_in,
  input  logic              inverse_in,
  output logic              source_valid,
  input  logic              source_ready,
  output logic              source_sop,
  output logic              source_eop,
  output logic [DATA_W-1:0] source_real,
  output logic [DATA_W-1:0] source_imag,
  output logic [1:0]        source_error,
  output logic [PTS_W-1:0]  fftpts_out,
  output logic              inverse_out,
  output logic [15:0]       drop_cnt
);

  localparam int WORD_W   = word_w(DATA_W, PTS_W);
  localparam int OFS_DATA = ofs_data();
  localparam int OFS_LEN  = ofs_len(DATA_W);
  localparam int OFS_INV  = ofs_inv(DATA_W, PTS_W);
  localparam int OFS_ERR  = ofs_err(DATA_W, PTS_W);
  localparam int OFS_EOP  = ofs_eop(DATA_W, PTS_W);
  localparam int OFS_SOP  = ofs_sop(DATA_W, PTS_W);

  wr_state_t          state_q;
  wr_state_t          state_nxt;

  // Frame context latched on the first beat
  logic [PTS_W-1:0]   beat_cnt;
  logic [PTS_W-1:0]   len_q;
  logic               inv_q;
  logic               err_q;
  logic [15:0]        drop_q;

  // Per-sample decode of the beat about to be written
  logic               len_legal;
  logic               take;
  logic [PTS_W-1:0]   beat_idx;
  logic [PTS_W-1:0]   beat_len;
  logic               beat_inv;
  logic               beat_err;
  logic               beat_sop;
  logic               beat_eop;
  logic               fifo_full;
  logic               write_beat;
  logic               drop_beat;

  logic [WORD_W-1:0]  wr_word;
  logic [WORD_W-1:0]  head_word;
  logic               head_valid;

  assign len_legal = is_legal_len(32'(fftpts_in), MIN_PTS, PTS_W);

  // Write-side state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state: a frame is entered on its first sample and left on its last
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take && !beat_eop) begin
          state_nxt = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (take && beat_eop) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Beat decode: in IDLE the live length/direction describe beat 0; inside a
  // frame the latched context is used so input changes are ignored.
  always_comb begin
    take     = 1'b0;
    beat_idx = '0;
    beat_len = len_q;
    beat_inv = inv_q;
    beat_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        take     = in_valid && enable && len_legal;
        beat_len = fftpts_in;
        beat_inv = inverse_in;
      end
      ST_FRAME: begin
        take     = in_valid;
        beat_idx = beat_cnt;
        beat_err = err_q;
      end
      default: ;
    endcase
  end

  assign beat_sop   = (beat_idx == '0);
  assign beat_eop   = (beat_idx == beat_len - 1'b1);
  assign write_beat = take && !fifo_full;
  assign drop_beat  = take && fifo_full;

  assign wr_word = {beat_sop, beat_eop, (beat_err ? ERR_DROP : ERR_NONE),
                    beat_inv, beat_len, in_data};

  // Frame context: beat counter advances on every taken sample, dropped or not
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
      len_q    <= '0;
      inv_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (take) begin
      if (beat_eop) begin
        beat_cnt <= '0;
        err_q    <= 1'b0;
      end else begin
        beat_cnt <= beat_idx + 1'b1;
        err_q    <= beat_err | drop_beat;
      end
      if (state_q == ST_IDLE) begin
        len_q <= fftpts_in;
        inv_q <= inverse_in;
      end
    end
  end

  // Saturating count of samples lost to a full buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (drop_beat && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (write_beat),
    .wr_data  (wr_word),
    .full     (fifo_full),
    .rd_en    (source_ready),
    .rd_data  (head_word),
    .rd_valid (head_valid)
  );

  // Source port is a direct view of the registered head word
  assign source_valid = head_valid;
  assign source_sop   = head_word[OFS_SOP];
  assign source_eop   = head_word[OFS_EOP];
  assign source_error = head_word[OFS_ERR +: 2];
  assign inverse_out  = head_word[OFS_INV];
  assign fftpts_out   = head_word[OFS_LEN +: PTS_W];
  assign source_real  = head_word[OFS_DATA +: DATA_W];
  assign source_imag  = '0;
  assign drop_cnt     = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_frame_packer
//  Description : Self-checking bench for fft_frame_packer. Directed frame
//                scenarios followed by random traffic, all compared against a
//                queue-based reference of the framing rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_frame_packer;

  localparam int DATA_W  = 12;
  localparam int PTS_W   = 13;
  localparam int DEPTH   = 16;
  localparam int MIN_PTS = 64;
  localparam int WW      = 5 + PTS_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [PTS_W-1:0]  fftpts_in;
  logic              inverse_in;
  logic              source_valid;
  logic              source_ready;
  logic              source_sop;
  logic              source_eop;
  logic [DATA_W-1:0] source_real;
  logic [DATA_W-1:0] source_imag;
  logic [1:0]        source_error;
  logic [PTS_W-1:0]  fftpts_out;
  logic              inverse_out;
  logic [15:0]       drop_cnt;

  always #5 clk = ~clk;

  fft_frame_packer #(
    .DATA_W     (DATA_W),
    .PTS_W      (PTS_W),
    .FIFO_DEPTH (DEPTH),
    .MIN_PTS    (MIN_PTS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .fftpts_in    (fftpts_in),
    .inverse_in   (inverse_in),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .source_error (source_error),
    .fftpts_out   (fftpts_out),
    .inverse_out  (inverse_out),
    .drop_cnt     (drop_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference: expected buffered beats plus the frame being collected
  logic [WW-1:0] mq[$];
  bit            m_in_frame = 0;
  int            m_len      = 0;
  int            m_idx      = 0;
  bit            m_inv      = 0;
  bit            m_err      = 0;
  int            m_drop     = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_legal(input int n);
    for (int k = 0; k < PTS_W; k++) begin
      if (n == (1 << k)) return (n >= MIN_PTS);
    end
    return 1'b0;
  endfunction

  // One clock of the reference, using the inputs the DUT sampled at this edge
  task automatic model_step();
    bit            full;
    bit            start;
    logic [WW-1:0] w;
    if (reset) begin
      mq.delete();
      m_in_frame = 0;
      m_idx      = 0;
      m_err      = 0;
      m_drop     = 0;
      return;
    end
    full = (mq.size() == DEPTH);
    if (source_ready && mq.size() > 0) void'(mq.pop_front());
    if (in_valid) begin
      start = 0;
      if (!m_in_frame && enable && ref_legal(int'(fftpts_in))) begin
        m_len = int'(fftpts_in);
        m_inv = inverse_in;
        m_idx = 0;
        m_err = 0;
        start = 1;
      end
      if (m_in_frame || start) begin
        w = {(m_idx == 0), (m_idx == m_len - 1), (m_err ? 2'b01 : 2'b00),
             m_inv, PTS_W'(m_len), in_data};
        if (full) begin
          if (m_drop < 65535) m_drop++;
          m_err = 1;
        end else begin
          mq.push_back(w);
        end
        m_idx++;
        m_in_frame = (m_idx != m_len);
      end
    end
  endtask

  task automatic step();
    logic [WW-1:0] got;
    @(posedge clk);
    model_step();
    #1;
    chk("valid", source_valid, (mq.size() > 0));
    if (mq.size() > 0) begin
      got = {source_sop, source_eop, source_error, inverse_out, fftpts_out, source_real};
      chk("head", got, mq[0]);
      chk("imag", source_imag, 0);
    end
    chk("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic drive(input bit v, input int d, input int pts, input bit inv,
                       input bit en, input bit rdy);
    in_valid     = v;
    in_data      = DATA_W'(d);
    fftpts_in    = PTS_W'(pts);
    inverse_in   = inv;
    enable       = en;
    source_ready = rdy;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 64, 0, 1, 1);
  endtask

  initial begin
    int  pts;
    bit  v;
    bit  rdy;
    bit  en;

    reset = 1'b1;
    in_valid = 0; in_data = '0; fftpts_in = '0; inverse_in = 0;
    enable = 0; source_ready = 0;

    // Reset state: every output low
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 64, 0, 1, 1);
      chk("reset_out", {source_valid, source_sop, source_eop, source_real, source_imag,
                        source_error, fftpts_out, inverse_out, drop_cnt}, 0);
    end
    reset = 1'b0;
    idle(2);

    // Basic 64-point frame, ready held high
    for (int i = 1; i <= 64; i++) begin
      drive(1, i, 64, 0, 1, 1);
      if (i == 1)
        chk("f64_first", {source_sop, source_eop, source_real, fftpts_out, source_error},
            {1'b1, 1'b0, 12'd1, 13'd64, 2'b00});
      if (i == 64)
        chk("f64_last", {source_sop, source_eop, source_real, fftpts_out, source_error},
            {1'b0, 1'b1, 12'd64, 13'd64, 2'b00});
    end
    idle(4);

    // Illegal length discarded without counting, then a 128-point frame
    for (int i = 1; i <= 10; i++) drive(1, i, 100, 0, 1, 1);
    for (int i = 11; i <= 138; i++) begin
      drive(1, i, 128, 1, 1, 1);
      if (i == 11)
        chk("f128_start", {source_sop, source_real, fftpts_out, inverse_out},
            {1'b1, 12'd11, 13'd128, 1'b1});
    end
    chk("illegal_nodrop", drop_cnt, 0);
    idle(4);

    // Overflow: 20 samples into a stalled sink, then drain concurrently
    for (int i = 1; i <= 20; i++) drive(1, i, 64, 0, 1, 0);
    drive(0, 0, 64, 0, 1, 1);
    for (int i = 21; i <= 64; i++) begin
      drive(1, i, 64, 0, 1, 1);
      if (i == 21) chk("ovf_drop", drop_cnt, 4);
    end
    idle(20);
    chk("ovf_drop_final", drop_cnt, 4);

    // Length change mid-frame takes effect only on the next frame
    for (int i = 0; i < 192; i++) begin
      drive(1, i + 200, (i < 30) ? 64 : 128, 0, 1, 1);
      if (i == 63)
        chk("chg_eop", {source_eop, fftpts_out}, {1'b1, 13'd64});
      if (i == 64)
        chk("chg_next", {source_sop, fftpts_out}, {1'b1, 13'd128});
    end
    idle(4);

    // Reset in the middle of a frame
    for (int i = 0; i < 40; i++) drive(1, i + 1, 64, 0, 1, 1);
    reset = 1'b1;
    drive(1, 99, 64, 0, 1, 1);
    chk("midreset_valid", source_valid, 0);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      drive(1, i + 500, 64, 0, 1, 1);
      if (i == 0)
        chk("post_reset_sop", {source_sop, source_real}, {1'b1, 12'(500)});
    end
    idle(4);

    // Random traffic, random back-pressure, occasional length/enable changes
    pts = 64;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 6))
          0: pts = 64;
          1: pts = 128;
          2: pts = 256;
          3: pts = 100;
          4: pts = 32;
          5: pts = 0;
          default: pts = 64;
        endcase
      end
      v   = ($urandom_range(0, 99) < 70);
      rdy = $urandom_range(0, 1);
      en  = ($urandom_range(0, 9) != 0);
      drive(v, int'($urandom), pts, $urandom_range(0, 1), en, rdy);
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
